video_stream_scheduler: RTL

- Packet-level round-robin scheduler that shares one video conversion stream pipeline (e.g. YUV422->444 unpacker) among NUM_SRC requester AXI-stream sources.
- Grants one source per packet, holds the grant until t_last, and tags each output beat with the source index on t_dest for downstream demux.
- Registered output stage, protected against runaway packets by a beat limit.

---
 rtl/video_stream_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/video_stream_scheduler.sv
// Packet-level round-robin scheduler sharing one AXI-stream output among NUM_SRC sources.
// A grant lasts until t_last or until the beat limit, and each output beat carries its source index on t_dest.
module video_stream_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 3,
    parameter int MAX_BEATS  = 4096,
    localparam int GW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_SRC-1:0]            src_t_valid,
    output logic [NUM_SRC-1:0]            src_t_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_t_data,
    input  logic [NUM_SRC-1:0]            src_t_last,
    input  logic [NUM_SRC*USER_WIDTH-1:0] src_t_user,
    input  logic [NUM_SRC-1:0]            src_enable,
    output logic                          dst_t_valid,
    input  logic                          dst_t_ready,
    output logic [DATA_WIDTH-1:0]         dst_t_data,
    output logic                          dst_t_last,
    output logic [USER_WIDTH-1:0]         dst_t_user,
    output logic [DEST_WIDTH-1:0]         dst_t_dest,
    output logic [DATA_WIDTH/8-1:0]       dst_t_keep,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          err_overlen,
    input  logic                          err_clear
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           r_last_grant;
    logic [CW-1:0]           r_beat_cnt;
    logic                    r_dst_valid;
    logic [DATA_WIDTH-1:0]   r_dst_data;
    logic                    r_dst_last;
    logic [USER_WIDTH-1:0]   r_dst_user;
    logic [DEST_WIDTH-1:0]   r_dst_dest;
    logic                    r_err;

    logic [NUM_SRC-1:0]      w_eligible;
    logic [GW-1:0]           w_cand;
    logic [GW-1:0]           w_winner;
    logic                    w_found;
    logic                    w_out_free;
    logic                    w_accept;
    logic                    w_limit;
    logic                    w_src_last;
    logic                    w_end_pkt;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int unsigned ofs);
        int unsigned sum;
        sum = (32'(base) + ofs) % NUM_SRC;
        return sum[GW-1:0];
    endfunction

    assign w_eligible = src_t_valid & src_enable;

    // Round-robin search starts one past the previous winner, so that source is considered last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_cand   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = wrap_idx(r_last_grant, k);
            if (!w_found && w_eligible[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_out_free = !r_dst_valid || dst_t_ready;
    assign w_src_last = src_t_last[r_grant];
    assign w_accept   = (r_state == S_GRANT) && src_t_valid[r_grant] && w_out_free;
    assign w_end_pkt  = w_accept && (w_src_last || w_limit);

    generate
        if (MAX_BEATS > 0) begin : g_limit
            assign w_limit = (r_beat_cnt == CW'(MAX_BEATS - 1));
        end else begin : g_no_limit
            assign w_limit = 1'b0;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign src_t_ready[gi] = (r_state == S_GRANT) && (r_grant == GW'(gi)) && w_out_free;
        end
    endgenerate

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found)   w_state_next = S_GRANT;
            S_GRANT: if (w_end_pkt) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_SRC - 1);
            r_beat_cnt   <= '0;
            r_dst_valid  <= 1'b0;
            r_dst_data   <= '0;
            r_dst_last   <= 1'b0;
            r_dst_user   <= '0;
            r_dst_dest   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant    <= w_winner;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
            end

            if (w_end_pkt) begin
                r_last_grant <= r_grant;
            end

            // A beat cut short by the limit is still marked last so downstream sees a closed packet.
            if (w_accept) begin
                r_dst_valid <= 1'b1;
                r_dst_data  <= src_t_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
                r_dst_user  <= src_t_user[r_grant*USER_WIDTH +: USER_WIDTH];
                r_dst_last  <= w_src_last || w_limit;
                r_dst_dest  <= DEST_WIDTH'(r_grant);
            end else if (dst_t_ready) begin
                r_dst_valid <= 1'b0;
            end

            if (w_accept && w_limit && !w_src_last) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign dst_t_valid = r_dst_valid;
    assign dst_t_data  = r_dst_data;
    assign dst_t_last  = r_dst_last;
    assign dst_t_user  = r_dst_user;
    assign dst_t_dest  = r_dst_dest;
    assign dst_t_keep  = '1;
    assign grant_id    = r_grant;
    assign busy        = (r_state == S_GRANT);
    assign err_overlen = r_err;

endmodule
